// File: rtl/calc_seq_arb.sv
// calc_seq_arb
//   Two-requester sequencer/arbiter in front of the four-operand
//   capture/calculate datapath. A 16-bit bundle accepted from either
//   requester is fed to the datapath as four nibble captures (op 0..3).
//   The sequencer then waits for the datapath's valid pulse and returns
//   the 5-bit result tagged with the owning requester id. A watchdog
//   aborts the transaction (and resets the datapath) if valid never
//   arrives within TIMEOUT cycles.
//
// Parameters
//   TIMEOUT       max WAIT cycles before abort (2..255)
//
// Ports
//   clock         system clock, rising edge
//   rst           synchronous active-high reset
//   req0_*        requester 0 valid/data/ready (A=[3:0] B=[7:4] C=[11:8] D=[15:12])
//   req1_*        requester 1 valid/data/ready, same packing
//   calc_d        nibble to datapath d_in
//   calc_op       datapath operand select
//   calc_capture  datapath capture strobe
//   calc_rst_n    active-low datapath reset
//   calc_result   datapath result
//   calc_valid    datapath one-cycle valid pulse
//   rsp_valid     response available
//   rsp_ready     consumer takes response
//   rsp_result    captured result (0 on abort)
//   rsp_id        requester owning the response
//   rsp_err       1 = watchdog abort
module calc_seq_arb #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [15:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_data,
  output logic        req1_ready,
  output logic [3:0]  calc_d,
  output logic [1:0]  calc_op,
  output logic        calc_capture,
  output logic        calc_rst_n,
  input  logic [4:0]  calc_result,
  input  logic        calc_valid,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [4:0]  rsp_result,
  output logic        rsp_id,
  output logic        rsp_err
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    ABORT,
    RESP
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        rr_ptr;
  logic [15:0] bundle;
  logic        id_q;
  logic [1:0]  op_cnt;
  logic [7:0]  timer;
  logic [4:0]  res_q;
  logic        err_q;
  // Registered datapath run flag: low for the cycle after a reset edge and
  // for the single ABORT cycle, so calc_rst_n is glitch-free.
  logic        run_q;

  logic        grant_id;
  logic        accept;

  // Arbitration: a lone requester wins; on contention rr_ptr decides.
  // No grant in the cycle directly after reset (run_q still low).
  always_comb begin
    grant_id   = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
    accept     = (state == IDLE) && run_q && !rst && (req0_valid || req1_valid);
    req0_ready = accept && !grant_id;
    req1_ready = accept && grant_id;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = LOAD;
      LOAD:    if (op_cnt == 2'd3) state_nx = WAIT;
      WAIT: begin
        if (calc_valid)                      state_nx = RESP;
        else if (timer == 8'(TIMEOUT - 1))   state_nx = ABORT;
      end
      ABORT:   state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= 1'b0;
      bundle <= '0;
      id_q   <= 1'b0;
      op_cnt <= '0;
      timer  <= '0;
      res_q  <= '0;
      err_q  <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      state <= state_nx;
      run_q <= (state_nx != ABORT);
      case (state)
        IDLE: begin
          if (accept) begin
            bundle <= grant_id ? req1_data : req0_data;
            id_q   <= grant_id;
            rr_ptr <= ~grant_id;
            op_cnt <= '0;
          end
        end
        LOAD: begin
          op_cnt <= op_cnt + 2'd1;
          if (op_cnt == 2'd3) timer <= '0;
        end
        WAIT: begin
          if (calc_valid) begin
            res_q <= calc_result;
            err_q <= 1'b0;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        ABORT: begin
          res_q <= '0;
          err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    calc_capture = (state == LOAD);
    calc_op      = (state == LOAD) ? op_cnt : 2'd0;
    calc_d       = (state == LOAD) ? bundle[{op_cnt, 2'b00} +: 4] : 4'd0;
    calc_rst_n   = run_q;
    rsp_valid    = (state == RESP);
    rsp_result   = (state == RESP) ? res_q : 5'd0;
    rsp_id       = (state == RESP) ? id_q : 1'b0;
    rsp_err      = (state == RESP) ? err_q : 1'b0;
  end

endmodule

// File: tb/tb_calc_seq_arb.sv
// Testbench for calc_seq_arb: a behavioural datapath stub (captures nibbles,
// pulses valid a programmable number of cycles after the last capture with
// the 5-bit sum of the four operands) plus directed and randomized scenarios
// checked against a transaction-level reference model.
module tb_calc_seq_arb;

  localparam int unsigned TIMEOUT = 8;

  logic        clock = 1'b0;
  logic        rst;
  logic        req0_valid;
  logic [15:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [15:0] req1_data;
  logic        req1_ready;
  logic [3:0]  calc_d;
  logic [1:0]  calc_op;
  logic        calc_capture;
  logic        calc_rst_n;
  logic [4:0]  calc_result;
  logic        calc_valid;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_result;
  logic        rsp_id;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;
  bit model_rr = 1'b0;

  always #5 clock = ~clock;

  calc_seq_arb #(.TIMEOUT(TIMEOUT)) dut (
    .clock        (clock),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_data    (req0_data),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_data    (req1_data),
    .req1_ready   (req1_ready),
    .calc_d       (calc_d),
    .calc_op      (calc_op),
    .calc_capture (calc_capture),
    .calc_rst_n   (calc_rst_n),
    .calc_result  (calc_result),
    .calc_valid   (calc_valid),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_id       (rsp_id),
    .rsp_err      (rsp_err)
  );

  // All outputs packed: r0 r1 d[4] op[2] cap rstn rv res[5] id err
  logic [17:0] outs;
  assign outs = {req0_ready, req1_ready, calc_d, calc_op, calc_capture,
                 calc_rst_n, rsp_valid, rsp_result, rsp_id, rsp_err};

  // Datapath stub
  logic [3:0] stub_ops [4];
  logic [5:0] stub_sum;
  int         stub_cnt = 0;
  int         stub_delay = 1;
  bit         stub_en = 1'b1;
  bit         stray_valid = 1'b0;

  always @(posedge clock) begin
    if (!calc_rst_n) begin
      for (int unsigned i = 0; i < 4; i++) stub_ops[i] <= '0;
    end else if (calc_capture) begin
      stub_ops[calc_op] <= calc_d;
    end
    if (stub_en && calc_capture && calc_op == 2'd3) stub_cnt <= stub_delay;
    else if (stub_cnt > 0)                          stub_cnt <= stub_cnt - 1;
  end

  always_comb begin
    stub_sum = 6'(stub_ops[0]) + 6'(stub_ops[1]) + 6'(stub_ops[2]) + 6'(stub_ops[3]);
  end

  assign calc_valid  = stray_valid || (stub_cnt == 1);
  assign calc_result = stray_valid ? 5'h15 : stub_sum[4:0];

  // Reference: datapath result is the sum of the four nibbles modulo 32.
  function automatic logic [4:0] ref_result(input logic [15:0] d);
    int unsigned s;
    s = int'(d[3:0]) + int'(d[7:4]) + int'(d[11:8]) + int'(d[15:12]);
    return 5'(s % 32);
  endfunction

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
    stray_valid = 1'b0;
    stub_en = 1'b1;
    stub_delay = 1;
    step();
    step();
    rst = 1'b0;
    step();
    model_rr = 1'b0;
  endtask

  task automatic present(input bit v0, input logic [15:0] d0, input bit v1,
                         input logic [15:0] d1, output bit g0, output bit g1);
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
    #1;
    g0 = req0_ready;
    g1 = req1_ready;
  endtask

  // Counts edges (including the accept edge when started at the grant
  // sample) until rsp_valid is seen, bounded.
  task automatic wait_rsp(input bit drop, output int edges, output bit seen);
    edges = 0;
    do begin
      step();
      edges++;
      if (drop && edges == 1) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end while (!rsp_valid && edges < 60);
    seen = rsp_valid;
  endtask

  task automatic complete();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data = 16'hFFFF;
    req1_data = 16'hFFFF;
    rsp_ready = 1'b1;
    stray_valid = 1'b0;
    step();
    step();
    checks++;
    if (outs !== 18'h00000) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", outs, 18'h00000);
    end
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
    step();
    checks++;
    if (outs !== 18'h00100) begin
      errors++;
      $display("FAIL post_reset_idle: got %h expected %h", outs, 18'h00100);
    end
    model_rr = 1'b0;
  endtask

  task automatic test_single();
    bit g0, g1, seen;
    logic [6:0] exp_ld;
    do_reset();
    stub_delay = 1;
    present(1'b1, 16'h4321, 1'b0, 16'h0000, g0, g1);
    checks++;
    if ({g0, g1} !== 2'b10) begin
      errors++;
      $display("FAIL single_grant: got %b expected %b", {g0, g1}, 2'b10);
    end
    step();
    req0_valid = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      exp_ld = {1'b1, 2'(k), 4'(k + 1)};
      checks++;
      if ({calc_capture, calc_op, calc_d} !== exp_ld) begin
        errors++;
        $display("FAIL single_load%0d: got %h expected %h", k, {calc_capture, calc_op, calc_d}, exp_ld);
      end
      step();
    end
    checks++;
    if ({calc_capture, rsp_valid} !== 2'b00) begin
      errors++;
      $display("FAIL single_wait: got %b expected %b", {calc_capture, rsp_valid}, 2'b00);
    end
    step();
    seen = rsp_valid;
    checks++;
    if ({seen, rsp_result, rsp_id, rsp_err} !== {1'b1, 5'h0A, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single_rsp: got %h expected %h", {seen, rsp_result, rsp_id, rsp_err}, {1'b1, 5'h0A, 1'b0, 1'b0});
    end
    complete();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_release: got %b expected %b", rsp_valid, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    bit g0, g1, seen;
    int edges;
    bit exp_id;
    logic [4:0] exp_res;
    do_reset();
    stub_delay = 1;
    present(1'b1, 16'h1111, 1'b1, 16'h2222, g0, g1);
    for (int unsigned i = 0; i < 4; i++) begin
      exp_id = 1'(i % 2);
      exp_res = exp_id ? ref_result(16'h2222) : ref_result(16'h1111);
      checks++;
      if ({g0, g1} !== {!exp_id, exp_id}) begin
        errors++;
        $display("FAIL contention_grant%0d: got %b expected %b", i, {g0, g1}, {!exp_id, exp_id});
      end
      wait_rsp(1'b0, edges, seen);
      checks++;
      if ({seen, rsp_id, rsp_result, rsp_err} !== {1'b1, exp_id, exp_res, 1'b0}) begin
        errors++;
        $display("FAIL contention_rsp%0d: got %h expected %h", i, {seen, rsp_id, rsp_result, rsp_err}, {1'b1, exp_id, exp_res, 1'b0});
      end
      complete();
      g0 = req0_ready;
      g1 = req1_ready;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    model_rr = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    bit g0, g1, seen;
    int edges;
    logic [7:0] held;
    do_reset();
    stub_delay = 1;
    present(1'b1, 16'h9753, 1'b0, 16'h0000, g0, g1);
    wait_rsp(1'b1, edges, seen);
    held = {seen, rsp_result, rsp_id, rsp_err};
    checks++;
    if (held !== {1'b1, ref_result(16'h9753), 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL bp_first_rsp: got %h expected %h", held, {1'b1, ref_result(16'h9753), 1'b0, 1'b0});
    end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data = 16'h1357;
    req1_data = 16'h2468;
    for (int unsigned i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({rsp_valid, rsp_result, rsp_id, rsp_err, req0_ready, req1_ready} !== {held, 2'b00}) begin
        errors++;
        $display("FAIL bp_hold%0d: got %h expected %h", i, {rsp_valid, rsp_result, rsp_id, rsp_err, req0_ready, req1_ready}, {held, 2'b00});
      end
    end
    complete();
    // rr pointer now favours requester 1
    checks++;
    if ({rsp_valid, req0_ready, req1_ready} !== 3'b001) begin
      errors++;
      $display("FAIL bp_release: got %b expected %b", {rsp_valid, req0_ready, req1_ready}, 3'b001);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    checks++;
    if ({rsp_valid, calc_capture} !== 2'b00) begin
      errors++;
      $display("FAIL bp_idle: got %b expected %b", {rsp_valid, calc_capture}, 2'b00);
    end
    model_rr = 1'b1;
  endtask

  task automatic test_timeout();
    bit g0, g1;
    int n, w;
    do_reset();
    stub_en = 1'b0;
    present(1'b0, 16'h0000, 1'b1, 16'hFEDC, g0, g1);
    step();
    req1_valid = 1'b0;
    n = 0;
    while (calc_capture && n < 10) begin
      n++;
      step();
    end
    w = 0;
    while (calc_rst_n && !rsp_valid && w < 40) begin
      w++;
      step();
    end
    checks++;
    if (w !== int'(TIMEOUT) || n !== 4) begin
      errors++;
      $display("FAIL timeout_wait_cycles: got %0d/%0d expected %0d/%0d", w, n, TIMEOUT, 4);
    end
    checks++;
    if ({calc_rst_n, rsp_valid} !== 2'b00) begin
      errors++;
      $display("FAIL timeout_abort: got %b expected %b", {calc_rst_n, rsp_valid}, 2'b00);
    end
    step();
    checks++;
    if ({calc_rst_n, rsp_valid, rsp_err, rsp_result, rsp_id} !== {1'b1, 1'b1, 1'b1, 5'h00, 1'b1}) begin
      errors++;
      $display("FAIL timeout_rsp: got %h expected %h", {calc_rst_n, rsp_valid, rsp_err, rsp_result, rsp_id}, {1'b1, 1'b1, 1'b1, 5'h00, 1'b1});
    end
    complete();
    stub_en = 1'b1;
    model_rr = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    bit g0, g1, seen;
    int edges;
    do_reset();
    stub_delay = 1;
    present(1'b1, 16'hABCD, 1'b0, 16'h0000, g0, g1);
    step();
    req0_valid = 1'b0;
    step();
    checks++;
    if ({calc_capture, calc_op} !== 3'b101) begin
      errors++;
      $display("FAIL rml_load1: got %b expected %b", {calc_capture, calc_op}, 3'b101);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    req1_valid = 1'b1;
    req1_data = 16'h5A3C;
    #1;
    checks++;
    if (outs !== 18'h00000) begin
      errors++;
      $display("FAIL rml_after_reset: got %h expected %h", outs, 18'h00000);
    end
    step();
    g1 = req1_ready;
    g0 = req0_ready;
    checks++;
    if ({g0, g1, calc_rst_n} !== 3'b011) begin
      errors++;
      $display("FAIL rml_fresh_grant: got %b expected %b", {g0, g1, calc_rst_n}, 3'b011);
    end
    wait_rsp(1'b1, edges, seen);
    checks++;
    if ({seen, rsp_id, rsp_result, rsp_err} !== {1'b1, 1'b1, ref_result(16'h5A3C), 1'b0} || edges != 6) begin
      errors++;
      $display("FAIL rml_fresh_rsp: got %h lat %0d expected %h lat 6", {seen, rsp_id, rsp_result, rsp_err}, edges, {1'b1, 1'b1, ref_result(16'h5A3C), 1'b0});
    end
    complete();
    model_rr = 1'b0;
  endtask

  task automatic test_stray_valid();
    bit g0, g1, seen;
    int edges;
    bit any_rsp;
    do_reset();
    stub_delay = 1;
    stray_valid = 1'b1;
    step();
    stray_valid = 1'b0;
    any_rsp = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      any_rsp |= rsp_valid;
      step();
    end
    checks++;
    if (any_rsp !== 1'b0) begin
      errors++;
      $display("FAIL stray_idle: got %b expected %b", any_rsp, 1'b0);
    end
    present(1'b1, 16'h1234, 1'b0, 16'h0000, g0, g1);
    step();
    req0_valid = 1'b0;
    step();
    stray_valid = 1'b1;
    step();
    stray_valid = 1'b0;
    wait_rsp(1'b0, edges, seen);
    checks++;
    if ({seen, rsp_result, rsp_err} !== {1'b1, 5'h0A, 1'b0} || edges != 3) begin
      errors++;
      $display("FAIL stray_load: got %h lat %0d expected %h lat 3", {seen, rsp_result, rsp_err}, edges, {1'b1, 5'h0A, 1'b0});
    end
    complete();
    model_rr = 1'b1;
  endtask

  task automatic test_random();
    bit v0, v1, g0, g1, seen, exp_id;
    logic [15:0] d0, d1;
    int d, edges, exp_edges;
    logic [6:0] exp_rsp;
    for (int unsigned it = 0; it < 40; it++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      d0 = 16'($urandom);
      d1 = 16'($urandom);
      if (!v0 && !v1) begin
        present(1'b0, d0, 1'b0, d1, g0, g1);
        checks++;
        if ({g0, g1} !== 2'b00) begin
          errors++;
          $display("FAIL rand_idle%0d: got %b expected %b", it, {g0, g1}, 2'b00);
        end
        step();
        continue;
      end
      d = int'($urandom_range(1, TIMEOUT + 2));
      stub_delay = d;
      exp_id = (v0 && v1) ? model_rr : v1;
      present(v0, d0, v1, d1, g0, g1);
      checks++;
      if ({g0, g1} !== {!exp_id, exp_id}) begin
        errors++;
        $display("FAIL rand_grant%0d: got %b expected %b", it, {g0, g1}, {!exp_id, exp_id});
      end
      model_rr = !exp_id;
      wait_rsp(1'b1, edges, seen);
      if (d <= int'(TIMEOUT)) begin
        exp_edges = 5 + d;
        exp_rsp = {exp_id, exp_id ? ref_result(d1) : ref_result(d0), 1'b0};
      end else begin
        exp_edges = int'(TIMEOUT) + 6;
        exp_rsp = {exp_id, 5'h00, 1'b1};
      end
      checks++;
      if (!seen || edges != exp_edges || {rsp_id, rsp_result, rsp_err} !== exp_rsp) begin
        errors++;
        $display("FAIL rand_rsp%0d: got %b %h lat %0d expected 1 %h lat %0d", it, seen, {rsp_id, rsp_result, rsp_err}, edges, exp_rsp, exp_edges);
      end
      repeat ($urandom_range(0, 3)) step();
      complete();
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL rand_release%0d: got %b expected %b", it, rsp_valid, 1'b0);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data = '0;
    req1_data = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_reset_mid_load();
    test_stray_valid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
